bit_perm_ctrl: RTL and testbench
================================

BIT_PERM_CTRL -- requirements
Module: bit_perm_ctrl

Interface
REQ-001 The block SHALL have one parameter: none; all widths are fixed (128-bit block, 32-bit word, 2-bit pass count).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream block is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the controller can accept a block.
REQ-006 The block SHALL have port in, input, 128 bits: the input state, with word 0 = in[127:96] and word 3 = in[31:0].
REQ-007 The block SHALL have port passes, input, 2 bits: the number of permutation passes minus 1, sampled at acceptance.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-010 The block SHALL have port out, output, 128 bits: the permuted state, with the same word ordering as in.
REQ-011 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 The block SHALL use a single shared 32-bit permute unit, one word per cycle; no parallel per-word instances are allowed.
REQ-013 The forward permute SHALL be defined as: for a=0..7, b=0..3, out_w[31-(4a+b)] = in_w[31-a-8b] (4x8 bit-matrix transpose).
REQ-014 The FSM SHALL have the states IDLE, PERM, DONE.
REQ-015 In IDLE: in_ready=1. On in_valid&in_ready, the block SHALL latch in into the work register and latch passes, set word_idx=0 and pass_cnt=0, and go to PERM.
REQ-016 In PERM: each cycle, the block SHALL replace word word_idx of the work register with permute(word) and increment word_idx (2-bit, wraps 3->0).
REQ-017 When word_idx=3 in PERM: if pass_cnt==latched passes, the block SHALL go to DONE; otherwise it SHALL increment pass_cnt and stay in PERM.
REQ-018 In DONE: out_valid=1 and out = work register, both held stable until out_ready=1; on out_valid&out_ready the block SHALL go to IDLE.
REQ-019 Latency SHALL be 4*(passes+1) cycles from the acceptance edge to the edge that raises out_valid; throughput is one block per 4*(passes+1)+2 cycles minimum.
REQ-020 in_ready SHALL be 0 in PERM and DONE; in_valid in those states SHALL be ignored, with no queuing.
REQ-021 in and passes changing after acceptance SHALL have no effect on the block in flight.
REQ-022 out_ready asserted while out_valid=0 SHALL have no effect.
REQ-023 out SHALL be 0 whenever out_valid=0.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, work register=0, word_idx=0, pass_cnt=0, out_valid=0, out=0, busy=0, in_ready=1 (held while rst=1? no: in_ready=0 while rst=1, 1 after release).
REQ-025 Reset mid-PERM or mid-DONE SHALL abort the block; no out_valid pulse SHALL appear for it after release.
REQ-026 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-027 The block SHALL support the macro BIT_PERM_INV_EN.
REQ-028 With BIT_PERM_INV_EN defined: the block SHALL have an extra port inv (input, 1 bit), sampled at acceptance; inv=1 applies the inverse permute out_w[31-a-8b] = in_w[31-(4a+b)] for every word of every pass; inv=0 applies the forward permute.
REQ-029 Without BIT_PERM_INV_EN: the inv port SHALL be absent and only the forward permute is built.

Verification
REQ-030 Reset then in=128'h00800000_00000080_80000000_00000001, passes=0 -> out_valid 4 cycles after acceptance, out=128'h40000000_10000000_80000000_00000001.
REQ-031 in=128'h00800000_00000000_00000000_00000000, passes=1 -> out_valid after 8 cycles, out=128'h08000000_00000000_00000000_00000000.
REQ-032 Any in, passes=0, out_ready held 0 for 10 cycles -> out_valid and out stable throughout, in_ready=0, and a second in_valid is not accepted.
REQ-033 Assert rst during PERM cycle 2 -> out_valid=0, out=0, busy=0, and no result appears after release; the next block completes normally.
REQ-034 With BIT_PERM_INV_EN: forward then inverse on in=128'h12345678_90abcdef_12345678_90abcdef (passes=3 each) -> the second out equals the original in.
REQ-035 Back-to-back: a held in_valid with out_ready=1 -> blocks accepted every 6 cycles (passes=0), with correct results for each.

Source files
------------

// File: rtl/bit_perm_ctrl_if.sv
// ---------------------------------------------------------------------------
// bit_perm_ctrl_if
// Handshake and data bundle for bit_perm_ctrl.
//
// Optional feature macro: BIT_PERM_INV_EN (adds the 1-bit inv select).
//
// Signals:
//   in_valid  - upstream block valid
//   in_ready  - controller can accept a block
//   in        - 128-bit input state, word 0 = in[127:96], word 3 = in[31:0]
//   passes    - number of permutation passes minus 1, sampled at acceptance
//   out_valid - result valid
//   out_ready - downstream accepts the result
//   out       - 128-bit permuted state, same word ordering as in
//   busy      - controller is not idle
//   inv       - (BIT_PERM_INV_EN only) 1 = inverse permute, sampled at acceptance
//
// Modports: slave = the controller, master = the environment driving it.
// ---------------------------------------------------------------------------
interface bit_perm_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in;
    logic [1:0]   passes;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out;
    logic         busy;
`ifdef BIT_PERM_INV_EN
    logic         inv;

    modport slave (
        input  in_valid, in, passes, out_ready, inv,
        output in_ready, out_valid, out, busy
    );

    modport master (
        output in_valid, in, passes, out_ready, inv,
        input  in_ready, out_valid, out, busy
    );
`else
    modport slave (
        input  in_valid, in, passes, out_ready,
        output in_ready, out_valid, out, busy
    );

    modport master (
        output in_valid, in, passes, out_ready,
        input  in_ready, out_valid, out, busy
    );
`endif
endinterface

// File: rtl/bit_perm_ctrl.sv
// ---------------------------------------------------------------------------
// bit_perm_ctrl
// Sequential 4x8 bit-matrix transpose of a 128-bit block, one 32-bit word
// per cycle through a single shared permute unit, repeated passes+1 times.
//
// Optional feature macro: BIT_PERM_INV_EN
//   defined   : bus.inv selects forward (0) or inverse (1) permute per block
//   undefined : forward permute only, no inv signal
//
// Ports:
//   clk - clock, all state changes on the rising edge
//   rst - asynchronous active-high reset
//   bus - bit_perm_ctrl_if.slave (handshake, data, passes, busy[, inv])
//
// States:
//   state | meaning
//   IDLE  | waiting for a block, in_ready=1 (when not in reset)
//   PERM  | permuting word word_idx of the work register each cycle
//   DONE  | result presented on out with out_valid=1 until out_ready
// ---------------------------------------------------------------------------
module bit_perm_ctrl (
    input  logic              clk,
    input  logic              rst,
    bit_perm_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PERM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] work_q, work_d;
    logic [1:0]   word_idx_q, word_idx_d;
    logic [1:0]   pass_cnt_q, pass_cnt_d;
    logic [1:0]   passes_q, passes_d;
`ifdef BIT_PERM_INV_EN
    logic         inv_q, inv_d;
`endif

    logic [31:0]  cur_word;
    logic [31:0]  perm_word;
    logic         accept;

    // Forward: out_w[31-(4a+b)] = in_w[31-a-8b]
    function automatic logic [31:0] perm_fwd(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 4; b++) begin
                r[31-(4*a+b)] = w[31-a-8*b];
            end
        end
        return r;
    endfunction

`ifdef BIT_PERM_INV_EN
    // Inverse: out_w[31-a-8b] = in_w[31-(4a+b)]
    function automatic logic [31:0] perm_inv(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 4; b++) begin
                r[31-a-8*b] = w[31-(4*a+b)];
            end
        end
        return r;
    endfunction
`endif

    // Word selector feeding the single shared permute unit
    always_comb begin
        cur_word = work_q[127:96];
        unique case (word_idx_q)
            2'd0: cur_word = work_q[127:96];
            2'd1: cur_word = work_q[95:64];
            2'd2: cur_word = work_q[63:32];
            2'd3: cur_word = work_q[31:0];
            default: cur_word = work_q[127:96];
        endcase
    end

`ifdef BIT_PERM_INV_EN
    assign perm_word = inv_q ? perm_inv(cur_word) : perm_fwd(cur_word);
`else
    assign perm_word = perm_fwd(cur_word);
`endif

    // in_ready is held low while reset is asserted, so acceptance cannot
    // coincide with a reset edge.
    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out       = (state_q == DONE) ? work_q : '0;
    assign bus.busy      = (state_q != IDLE);
    assign accept        = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            work_q     <= '0;
            word_idx_q <= '0;
            pass_cnt_q <= '0;
            passes_q   <= '0;
`ifdef BIT_PERM_INV_EN
            inv_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            word_idx_q <= word_idx_d;
            pass_cnt_q <= pass_cnt_d;
            passes_q   <= passes_d;
`ifdef BIT_PERM_INV_EN
            inv_q      <= inv_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        word_idx_d = word_idx_q;
        pass_cnt_d = pass_cnt_q;
        passes_d   = passes_q;
`ifdef BIT_PERM_INV_EN
        inv_d      = inv_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    work_d     = bus.in;
                    passes_d   = bus.passes;
                    word_idx_d = 2'd0;
                    pass_cnt_d = 2'd0;
`ifdef BIT_PERM_INV_EN
                    inv_d      = bus.inv;
`endif
                    state_d    = PERM;
                end
            end

            PERM: begin
                unique case (word_idx_q)
                    2'd0: work_d[127:96] = perm_word;
                    2'd1: work_d[95:64]  = perm_word;
                    2'd2: work_d[63:32]  = perm_word;
                    2'd3: work_d[31:0]   = perm_word;
                    default: work_d      = work_q;
                endcase
                word_idx_d = word_idx_q + 2'd1;
                if (word_idx_q == 2'd3) begin
                    if (pass_cnt_q == passes_q) begin
                        state_d = DONE;
                    end else begin
                        pass_cnt_d = pass_cnt_q + 2'd1;
                    end
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bit_perm_ctrl.sv
module tb_bit_perm_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   cyc;

    bit_perm_ctrl_if bus ();

    bit_perm_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: spec bit-mapping rule applied to each word, passes+1 times.
    function automatic logic [31:0] ref_word(input logic [31:0] w, input bit inv);
        logic [31:0] r;
        r = '0;
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 4; b++)
                if (!inv) r[31-(4*a+b)] = w[31-a-8*b];
                else      r[31-a-8*b]   = w[31-(4*a+b)];
        return r;
    endfunction

    function automatic logic [127:0] ref_block(input logic [127:0] d, input int np, input bit inv);
        logic [31:0] words [4];
        for (int k = 0; k < 4; k++) words[k] = d[127-32*k -: 32];
        for (int p = 0; p <= np; p++)
            for (int k = 0; k < 4; k++) words[k] = ref_word(words[k], inv);
        return {words[0], words[1], words[2], words[3]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_inv(input bit v);
`ifdef BIT_PERM_INV_EN
        bus.inv = v;
`endif
    endtask

    // Accept one block, measure latency, check result, optional hold, handshake.
    task automatic run_block(input logic [127:0] d, input logic [1:0] p, input bit inv,
                             input int hold, input bit early_rdy, input string tag,
                             output logic [127:0] got);
        logic [127:0] expv;
        int lat;
        int waitc;
        expv = ref_block(d, int'(p), inv);
        bus.in = d;
        bus.passes = p;
        set_inv(inv);
        bus.in_valid = 1'b1;
        waitc = 0;
        while (!bus.in_ready && waitc < 20) begin step(); waitc++; end
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL %s in_ready before accept: got %b want 1", tag, bus.in_ready);
        else n_pass++;
        step();
        bus.in_valid = 1'b0;
        bus.in = {$urandom, $urandom, $urandom, $urandom};
        bus.passes = 2'($urandom);
        set_inv(!inv);
        if (early_rdy) bus.out_ready = 1'b1;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin step(); lat++; end
        n_checks++;
        if (lat !== 4 * (int'(p) + 1)) $display("FAIL %s latency: got %0d want %0d", tag, lat, 4 * (int'(p) + 1));
        else n_pass++;
        got = bus.out;
        n_checks++;
        if (bus.out !== expv) $display("FAIL %s out: got %h want %h", tag, bus.out, expv);
        else n_pass++;
        if (hold > 0) begin
            repeat (hold) step();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out !== expv)
                $display("FAIL %s held out: got v=%b %h want v=1 %h", tag, bus.out_valid, bus.out, expv);
            else n_pass++;
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out !== '0 || bus.busy !== 1'b0)
            $display("FAIL %s after handshake: got v=%b out=%h busy=%b want 0/0/0", tag, bus.out_valid, bus.out, bus.busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic [127:0] g;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in = '0;
        bus.passes = '0;
        bus.out_ready = 1'b0;
        set_inv(1'b0);
        #2;
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out !== '0 || bus.busy !== 1'b0)
            $display("FAIL reset state: got rdy=%b v=%b out=%h busy=%b want 0/0/0/0",
                     bus.in_ready, bus.out_valid, bus.out, bus.busy);
        else n_pass++;
        step();
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset release in_ready: got %b want 1", bus.in_ready);
        else n_pass++;
        // first acceptance on the very next edge
        run_block(128'h00800000_00000080_80000000_00000001, 2'd0, 1'b0, 0, 1'b0, "vec_p0", g);
        n_checks++;
        if (g !== 128'h40000000_10000000_80000000_00000001)
            $display("FAIL vec_p0 literal: got %h want %h", g, 128'h40000000_10000000_80000000_00000001);
        else n_pass++;
    endtask

    task automatic test_vectors();
        logic [127:0] g;
        run_block(128'h00800000_00000000_00000000_00000000, 2'd1, 1'b0, 0, 1'b0, "vec_p1", g);
        n_checks++;
        if (g !== 128'h08000000_00000000_00000000_00000000)
            $display("FAIL vec_p1 literal: got %h want %h", g, 128'h08000000_00000000_00000000_00000000);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [127:0] g;
        logic [127:0] d;
        logic [1:0] p;
        int hold;
        bit early;
        for (int i = 0; i < 24; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            p = 2'($urandom_range(0, 3));
            hold = int'($urandom_range(0, 3));
            early = (hold == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
`ifdef BIT_PERM_INV_EN
            run_block(d, p, 1'($urandom_range(0, 1)), hold, early, "random", g);
`else
            run_block(d, p, 1'b0, hold, early, "random", g);
`endif
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    task automatic test_hold();
        logic [127:0] d;
        logic [127:0] expv;
        int bad;
        int waitc;
        d = {$urandom, $urandom, $urandom, $urandom};
        expv = ref_block(d, 0, 1'b0);
        bus.in = d;
        bus.passes = 2'd0;
        set_inv(1'b0);
        bus.in_valid = 1'b1;
        step();
        bus.in = ~d;
        waitc = 0;
        while (!bus.out_valid && waitc < 20) begin step(); waitc++; end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid !== 1'b1 || bus.out !== expv || bus.in_ready !== 1'b0) bad++;
            step();
        end
        n_checks++;
        if (bad !== 0) $display("FAIL hold stability: got %0d bad cycles want 0", bad);
        else n_pass++;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) bad++;
            step();
        end
        n_checks++;
        if (bad !== 0) $display("FAIL hold no queued accept: got %0d busy cycles want 0", bad);
        else n_pass++;
    endtask

    task automatic test_abort();
        logic [127:0] g;
        int bad;
        bus.in = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        bus.passes = 2'd2;
        set_inv(1'b0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out !== '0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0)
            $display("FAIL abort in reset: got v=%b out=%h busy=%b rdy=%b want 0/0/0/0",
                     bus.out_valid, bus.out, bus.busy, bus.in_ready);
        else n_pass++;
        step();
        rst = 1'b0;
        #1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
            step();
        end
        n_checks++;
        if (bad !== 0) $display("FAIL abort no result: got %0d active cycles want 0", bad);
        else n_pass++;
        run_block({$urandom, $urandom, $urandom, $urandom}, 2'd3, 1'b0, 1, 1'b0, "after_abort", g);
    endtask

    task automatic test_back_to_back();
        logic [127:0] data [5];
        logic [127:0] expv;
        int acc [5];
        int waitc;
        for (int k = 0; k < 5; k++) data[k] = {$urandom, $urandom, $urandom, $urandom};
        bus.passes = 2'd0;
        set_inv(1'b0);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.in = data[k];
            expv = ref_block(data[k], 0, 1'b0);
            waitc = 0;
            while (!bus.in_ready && waitc < 20) begin step(); waitc++; end
            acc[k] = cyc;
            step();
            waitc = 0;
            while (!bus.out_valid && waitc < 20) begin step(); waitc++; end
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out !== expv)
                $display("FAIL b2b out[%0d]: got v=%b %h want v=1 %h", k, bus.out_valid, bus.out, expv);
            else n_pass++;
            step();
            if (k > 0) begin
                n_checks++;
                if (acc[k] - acc[k-1] !== 6)
                    $display("FAIL b2b interval[%0d]: got %0d want 6", k, acc[k] - acc[k-1]);
                else n_pass++;
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
    endtask

`ifdef BIT_PERM_INV_EN
    task automatic test_inverse();
        logic [127:0] g1;
        logic [127:0] g2;
        run_block(128'h12345678_90abcdef_12345678_90abcdef, 2'd3, 1'b0, 0, 1'b0, "inv_fwd", g1);
        run_block(g1, 2'd3, 1'b1, 0, 1'b0, "inv_inv", g2);
        n_checks++;
        if (g2 !== 128'h12345678_90abcdef_12345678_90abcdef)
            $display("FAIL inverse roundtrip: got %h want %h", g2, 128'h12345678_90abcdef_12345678_90abcdef);
        else n_pass++;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_pass = 0;
        cyc = 0;
        test_reset();
        test_vectors();
        test_hold();
        test_abort();
        test_back_to_back();
`ifdef BIT_PERM_INV_EN
        test_inverse();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
